// File: rtl/wb_interconnect_nslv.sv
// Registered single-master / NUM_SLV-slave Wishbone interconnect.
// The slave index is decoded from the address, and the request is held until
// the selected slave acks or the bus times out. The master gets a one-cycle
// registered ack or err, with read data valid only in that cycle.
module wb_interconnect_nslv #(
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int SLV_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [31:0]           m0_wb_dat_i,
  input  logic [31:0]           m0_wb_adr_i,
  input  logic [3:0]            m0_wb_sel_i,
  input  logic                  m0_wb_we_i,
  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  output logic [31:0]           m0_wb_dat_o,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_err_o,
  input  logic [32*NUM_SLV-1:0] s_wb_dat_i,
  input  logic [NUM_SLV-1:0]    s_wb_ack_i,
  output logic [31:0]           s_wb_dat_o,
  output logic [SLV_AW-1:0]     s_wb_adr_o,
  output logic [3:0]            s_wb_sel_o,
  output logic                  s_wb_we_o,
  output logic [NUM_SLV-1:0]    s_wb_cyc_o,
  output logic [NUM_SLV-1:0]    s_wb_stb_o
);
  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SW:0]  NSLV    = NUM_SLV[SW:0];
  localparam logic [15:0]  TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DERR, RESP} state_e;

  state_e              state_q, state_d;
  logic [31:0]         dat_q, dat_d, rdat_q, rdat_d;
  logic [SLV_AW-1:0]   adr_q, adr_d;
  logic [3:0]          sel_q, sel_d;
  logic                we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic [SW-1:0]       tid_q, tid_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [NUM_SLV-1:0][31:0] sdat;
  logic [SW-1:0]            tid_in;
  logic                     req, hit, slv_ack, last;

  assign sdat    = s_wb_dat_i;
  assign tid_in  = m0_wb_adr_i[SEL_LSB +: SW];
  assign req     = m0_wb_cyc_i & m0_wb_stb_i;
  // Non-power-of-two slave counts leave unused indices: those are decode misses.
  assign hit     = {1'b0, tid_in} < NSLV;
  // Only the selected slave's ack is ever looked at.
  assign slv_ack = s_wb_ack_i[tid_q];
  assign last    = (cnt_q == TO_LAST);

  // State and datapath registers; reset drops slave strobes asynchronously.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      tid_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      tid_q   <= tid_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next state; a master abort in REQ beats a same-cycle slave ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = hit ? REQ : DERR;
      REQ: begin
        if (!m0_wb_cyc_i)        state_d = IDLE;
        else if (slv_ack || last) state_d = RESP;
      end
      DERR:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout count and the one-cycle response pulse.
  always_comb begin
    dat_d  = dat_q;
    adr_d  = adr_q;
    sel_d  = sel_q;
    we_d   = we_q;
    tid_d  = tid_q;
    cnt_d  = '0;
    rdat_d = '0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        dat_d = m0_wb_dat_i;
        adr_d = m0_wb_adr_i[SLV_AW+1:2];
        sel_d = m0_wb_sel_i;
        we_d  = m0_wb_we_i;
        tid_d = tid_in;
      end
      REQ: begin
        if (m0_wb_cyc_i) begin
          if (slv_ack) begin
            ack_d  = 1'b1;
            rdat_d = we_q ? 32'h0 : sdat[tid_q];
          end else if (last) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      DERR:    err_d = 1'b1;
      default: ;
    endcase
  end

  assign m0_wb_dat_o = rdat_q;
  assign m0_wb_ack_o = ack_q;
  assign m0_wb_err_o = err_q;
  assign s_wb_dat_o  = dat_q;
  assign s_wb_adr_o  = adr_q;
  assign s_wb_sel_o  = sel_q;
  assign s_wb_we_o   = we_q;

  // One-hot slave cycle/strobe, live only while the request is outstanding.
  for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
    assign s_wb_cyc_o[k] = (state_q == REQ) && (tid_q == SW'(k));
    assign s_wb_stb_o[k] = s_wb_cyc_o[k];
  end
endmodule

// File: tb/tb_wb_interconnect_nslv.sv
// Directed bench for wb_interconnect_nslv: a 4-slave instance with a short
// timeout and a 3-slave instance for the decode-miss path.
module tb_wb_interconnect_nslv;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [31:0]  m_dat, m_adr, m_rdat;
  logic [3:0]   m_sel;
  logic         m_we, m_cyc, m_stb, m_ack, m_err;
  logic [127:0] s_rdat;
  logic [3:0]   s_ack, s_cyc, s_stb, s_sel;
  logic [31:0]  s_wdat;
  logic [9:0]   s_adr;
  logic         s_we;

  logic [31:0]  m3_adr, m3_rdat, s3_wdat;
  logic         m3_cyc, m3_stb, m3_ack, m3_err, s3_we;
  logic [2:0]   s3_cyc, s3_stb;
  logic [9:0]   s3_adr;
  logic [3:0]   s3_sel;

  wb_interconnect_nslv #(.NUM_SLV(4), .SEL_LSB(12), .SLV_AW(10), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .m0_wb_dat_i(m_dat), .m0_wb_adr_i(m_adr), .m0_wb_sel_i(m_sel),
    .m0_wb_we_i(m_we), .m0_wb_cyc_i(m_cyc), .m0_wb_stb_i(m_stb),
    .m0_wb_dat_o(m_rdat), .m0_wb_ack_o(m_ack), .m0_wb_err_o(m_err),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
    .s_wb_dat_o(s_wdat), .s_wb_adr_o(s_adr), .s_wb_sel_o(s_sel),
    .s_wb_we_o(s_we), .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb)
  );

  wb_interconnect_nslv #(.NUM_SLV(3), .SEL_LSB(12), .SLV_AW(10), .TIMEOUT(8)) dut3 (
    .clk_i(clk_i), .rst_n(rst_n),
    .m0_wb_dat_i(32'h0), .m0_wb_adr_i(m3_adr), .m0_wb_sel_i(4'hF),
    .m0_wb_we_i(1'b0), .m0_wb_cyc_i(m3_cyc), .m0_wb_stb_i(m3_stb),
    .m0_wb_dat_o(m3_rdat), .m0_wb_ack_o(m3_ack), .m0_wb_err_o(m3_err),
    .s_wb_dat_i(96'h0), .s_wb_ack_i(3'b000),
    .s_wb_dat_o(s3_wdat), .s_wb_adr_o(s3_adr), .s_wb_sel_o(s3_sel),
    .s_wb_we_o(s3_we), .s_wb_cyc_o(s3_cyc), .s_wb_stb_o(s3_stb)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic master(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m_adr = adr; m_we = we; m_dat = dat; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic idle_m();
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  initial begin
    m_dat = '0; m_adr = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_rdat = '0; s_ack = '0;
    m3_adr = '0; m3_cyc = 1'b0; m3_stb = 1'b0;

    // Reset state
    #12;
    chk("rst_ack", {31'b0, m_ack}, 32'h0);
    chk("rst_err", {31'b0, m_err}, 32'h0);
    chk("rst_dat", m_rdat, 32'h0);
    chk("rst_cyc", {28'b0, s_cyc}, 32'h0);
    chk("rst_wdat", s_wdat, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // T1: write to slave 0, slave acks in its first strobe cycle
    master(32'h0000_0010, 1'b1, 32'hA5A5_5A5A);
    chk("t1_idle_cyc", {28'b0, s_cyc}, 32'h0);
    step();
    chk("t1_cyc", {28'b0, s_cyc}, 32'h1);
    chk("t1_stb", {28'b0, s_stb}, 32'h1);
    chk("t1_adr", {22'b0, s_adr}, 32'h004);
    chk("t1_wdat", s_wdat, 32'hA5A5_5A5A);
    chk("t1_we", {31'b0, s_we}, 32'h1);
    chk("t1_sel", {28'b0, s_sel}, 32'hF);
    chk("t1_noack", {31'b0, m_ack}, 32'h0);
    s_ack = 4'b0001; s_rdat[31:0] = 32'hDEAD_BEEF;
    step();
    s_ack = 4'b0000; idle_m();
    chk("t1_ack", {31'b0, m_ack}, 32'h1);
    chk("t1_err", {31'b0, m_err}, 32'h0);
    chk("t1_wr_dat0", m_rdat, 32'h0);
    chk("t1_cyc_drop", {28'b0, s_cyc}, 32'h0);
    step();
    chk("t1_ack_1cyc", {31'b0, m_ack}, 32'h0);

    // T2: read slave 2 with 5-cycle ack; a stray ack from slave 1 is ignored
    s_rdat = {32'h0, 32'h1234_5678, 32'h5555_5555, 32'h6666_6666};
    master(32'h0000_2008, 1'b0, 32'h0);
    step();
    chk("t2_stb", {28'b0, s_stb}, 32'h4);
    chk("t2_adr", {22'b0, s_adr}, 32'h002);
    s_ack = 4'b0010;
    step();
    s_ack = 4'b0000;
    chk("t2_stray_ack", {31'b0, m_ack}, 32'h0);
    chk("t2_stray_stb", {28'b0, s_stb}, 32'h4);
    step(); step(); step();
    chk("t2_wait_stb", {28'b0, s_stb}, 32'h4);
    s_ack = 4'b0100;
    step();
    s_ack = 4'b0000; idle_m();
    chk("t2_ack", {31'b0, m_ack}, 32'h1);
    chk("t2_dat", m_rdat, 32'h1234_5678);
    step();
    chk("t2_dat_after", m_rdat, 32'h0);
    chk("t2_ack_after", {31'b0, m_ack}, 32'h0);

    // T3: slave 3 never acks, TIMEOUT=8 -> 8 strobe cycles then err
    begin
      int hi = 0;
      s_rdat[127:96] = 32'h7777_7777;
      master(32'h0000_3000, 1'b0, 32'h0);
      step();
      for (int i = 0; i < 12 && s_stb == 4'b1000; i++) begin
        hi++;
        step();
      end
      idle_m();
      chk("t3_req_cycles", hi, 8);
      chk("t3_err", {31'b0, m_err}, 32'h1);
      chk("t3_ack", {31'b0, m_ack}, 32'h0);
      chk("t3_dat", m_rdat, 32'h0);
      chk("t3_stb_drop", {28'b0, s_stb}, 32'h0);
      step();
      chk("t3_err_1cyc", {31'b0, m_err}, 32'h0);
    end

    // T4: 3-slave instance, index 3 is a decode miss
    m3_adr = 32'h0000_3000; m3_cyc = 1'b1; m3_stb = 1'b1;
    step();
    chk("t4_nocyc", {29'b0, s3_cyc}, 32'h0);
    chk("t4_err_early", {31'b0, m3_err}, 32'h0);
    step();
    m3_cyc = 1'b0; m3_stb = 1'b0;
    chk("t4_err", {31'b0, m3_err}, 32'h1);
    chk("t4_ack", {31'b0, m3_ack}, 32'h0);
    chk("t4_nostb", {29'b0, s3_stb}, 32'h0);
    step();
    chk("t4_err_1cyc", {31'b0, m3_err}, 32'h0);

    // T5: master abort in REQ wins over a same-cycle ack
    master(32'h0000_0000, 1'b0, 32'h0);
    step();
    chk("t5_stb", {28'b0, s_stb}, 32'h1);
    idle_m(); s_ack = 4'b0001;
    step();
    s_ack = 4'b0000;
    chk("t5_abort_cyc", {28'b0, s_cyc}, 32'h0);
    chk("t5_abort_ack", {31'b0, m_ack}, 32'h0);
    chk("t5_abort_err", {31'b0, m_err}, 32'h0);
    step();
    chk("t5_no_late", {30'b0, m_ack, m_err}, 32'h0);

    // T6: asynchronous reset mid-request, then a normal transfer
    master(32'h0000_1004, 1'b0, 32'h0);
    step();
    chk("t6_stb", {28'b0, s_stb}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", {28'b0, s_cyc}, 32'h0);
    chk("t6_rst_adr", {22'b0, s_adr}, 32'h0);
    idle_m();
    step();
    rst_n = 1'b1;
    step();
    s_rdat[63:32] = 32'hCAFE_F00D;
    master(32'h0000_1004, 1'b0, 32'h0);
    step();
    chk("t6_stb2", {28'b0, s_stb}, 32'h2);
    chk("t6_adr2", {22'b0, s_adr}, 32'h001);
    s_ack = 4'b0010;
    step();
    s_ack = 4'b0000; idle_m();
    chk("t6_ack", {31'b0, m_ack}, 32'h1);
    chk("t6_dat", m_rdat, 32'hCAFE_F00D);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
